// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array geometry and IFM feeder FSM encoding
package systolic_pkg;
    localparam int SYSTOLIC_SIZE = 16;
    localparam int DATA_WIDTH    = 16;
    localparam int KERNEL_SIZE   = 3;
    localparam int IFM_CHANNEL   = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage register chain carrying one lane's valid bit and data
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;
    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else begin
            pipe[0] <= d;
            for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/ifm_skew_feeder.sv
// ifm_skew_feeder: captures IFM vectors and skews lane i by i cycles; IFM_LANE_MASK_EN zeroes lanes >= size
module ifm_skew_feeder
    import systolic_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                read_en,
    input  logic [4:0]                          size,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] mem_data,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_out,
    output logic [SYSTOLIC_SIZE-1:0]            lane_valid,
    output logic                                busy,
    output logic                                tile_done,
    output logic                                overflow
);
    localparam int VECS = IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE;
    localparam int VW   = $clog2(VECS + 1);
    localparam int CW   = $clog2(SYSTOLIC_SIZE);
    localparam int LW   = DATA_WIDTH + 1;
    state_t state, state_nxt;
    logic [MEM_LATENCY-1:0] rd_dly;
    logic [VW-1:0] vec_cnt;
    logic [CW-1:0] drain_cnt;
    logic [4:0] size_q;
    logic data_vld, fill_last, drain_last;
    assign data_vld   = rd_dly[MEM_LATENCY-1];
    assign fill_last  = data_vld && vec_cnt == VW'(VECS - 1);
    assign drain_last = drain_cnt == CW'(SYSTOLIC_SIZE - 1);
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = (state == IDLE  && data_vld)   ? FILL  :
                    (state == FILL  && fill_last)  ? DRAIN :
                    (state == DRAIN && drain_last) ? IDLE  : state;
    end
    always_comb begin
        busy      = state != IDLE;
        tile_done = state == DRAIN && drain_last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dly    <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            size_q    <= '0;
            overflow  <= 1'b0;
        end else begin
            rd_dly[0] <= read_en;
            for (int k = 1; k < MEM_LATENCY; k++) rd_dly[k] <= rd_dly[k-1];
            if (state == IDLE && data_vld) begin
                vec_cnt <= VW'(1);
                size_q  <= size;
            end else if (state == FILL && data_vld) vec_cnt <= vec_cnt + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            if (state == DRAIN && data_vld) overflow <= 1'b1;
        end
    end
`ifdef IFM_LANE_MASK_EN
    // the first vector of a tile must see size before size_q has latched it
    logic [4:0] size_eff;
    assign size_eff = (state == IDLE) ? size : size_q;
`else
    logic unused_size;
    assign unused_size = ^size_q;
`endif
    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
        logic en;
        logic [LW-1:0] d, q;
`ifdef IFM_LANE_MASK_EN
        assign en = data_vld && 5'(i) < size_eff;
`else
        assign en = data_vld;
`endif
        assign d = en ? {1'b1, mem_data[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
        skew_delay_line #(.DEPTH(i + 1), .WIDTH(LW)) u_dl (.clk(clk), .rst(rst), .d(d), .q(q));
        assign lane_valid[i] = q[LW-1];
        assign ifm_out[i*DATA_WIDTH +: DATA_WIDTH] = q[LW-1] ? q[DATA_WIDTH-1:0] : '0;
    end
endmodule

// File: tb/tb_ifm_skew_feeder.sv
// tb_ifm_skew_feeder: table-driven tile scenarios plus reset and back-to-back sequences
module tb_ifm_skew_feeder;
    localparam int N = 16;
    localparam int WIN = 100;
`ifdef IFM_LANE_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif
    typedef struct {
        int n; int gap; int ext_at; int t2_at;
        logic [4:0] size; logic [15:0] base; logic [15:0] linc; logic [15:0] step;
        int e_l0_first; int e_l15_first; int e_l0_cnt; int e_l15_cnt; int e_lanes;
        int e_l0_span; int e_done_n; int e_done0; int e_done1; int e_ovf;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, read_en = 1'b0;
    logic [4:0] size = 5'd16;
    logic [N*16-1:0] mem_data = '0;
    logic [N*16-1:0] ifm_out;
    logic [N-1:0] lane_valid;
    logic busy, tile_done, overflow;
    int passed = 0, total = 0;
    int first_c [N], last_c [N], cnt [N];
    int bad_data, leak, done_n, done_at0, done_at1;
    vec_t tbl [6];
    ifm_skew_feeder dut (
        .clk(clk), .rst(rst), .read_en(read_en), .size(size), .mem_data(mem_data),
        .ifm_out(ifm_out), .lane_valid(lane_valid), .busy(busy), .tile_done(tile_done),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask
    function automatic logic [15:0] lane_val(input vec_t v, input int l, input int s);
        return v.base + 16'(l) * v.linc + 16'(s) * v.step;
    endfunction
    function automatic logic [N*16-1:0] vec_data(input vec_t v, input int s);
        logic [N*16-1:0] r;
        for (int l = 0; l < N; l++) r[l*16 +: 16] = lane_val(v, l, s);
        return r;
    endfunction
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        read_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic run_stream(input vec_t v);
        int s, prev;
        logic [15:0] o;
        for (int l = 0; l < N; l++) begin first_c[l] = -1; last_c[l] = -1; cnt[l] = 0; end
        bad_data = 0; leak = 0; done_n = 0; done_at0 = -1; done_at1 = -1;
        s = 0; prev = -1;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            for (int l = 0; l < N; l++) begin
                o = ifm_out[l*16 +: 16];
                if (lane_valid[l]) begin
                    if (first_c[l] < 0) first_c[l] = c;
                    last_c[l] = c;
                    if (o !== lane_val(v, l, cnt[l])) bad_data++;
                    cnt[l]++;
                end else if (o !== 16'h0) leak++;
            end
            if (tile_done) begin
                if (done_n == 0) done_at0 = c; else done_at1 = c;
                done_n++;
            end
            size = v.size;
            mem_data = (prev >= 0) ? vec_data(v, prev) : {N{16'hDEAD}};
            prev = -1;
            read_en = 1'b0;
            if ((s < v.n && c == s * (v.gap + 1)) ||
                (v.t2_at >= 0 && s >= v.n && s < 2 * v.n && c == v.t2_at + s - v.n) ||
                (v.ext_at >= 0 && c == v.ext_at)) begin
                read_en = 1'b1;
                prev = s;
                s++;
            end
        end
    endtask
    task automatic check_run(input int k, input vec_t v);
        int lanes;
        lanes = 0;
        for (int l = 0; l < N; l++) if (cnt[l] > 0) lanes++;
        chk($sformatf("t%0d l0_first", k), first_c[0], v.e_l0_first);
        chk($sformatf("t%0d l15_first", k), first_c[N-1], v.e_l15_first);
        chk($sformatf("t%0d l0_cnt", k), cnt[0], v.e_l0_cnt);
        chk($sformatf("t%0d l15_cnt", k), cnt[N-1], v.e_l15_cnt);
        chk($sformatf("t%0d lanes_on", k), lanes, v.e_lanes);
        chk($sformatf("t%0d l0_span", k), (first_c[0] < 0) ? 0 : last_c[0] - first_c[0] + 1, v.e_l0_span);
        chk($sformatf("t%0d bad_data", k), bad_data, 0);
        chk($sformatf("t%0d leak", k), leak, 0);
        chk($sformatf("t%0d done_n", k), done_n, v.e_done_n);
        chk($sformatf("t%0d done_at0", k), done_at0, v.e_done0);
        chk($sformatf("t%0d done_at1", k), done_at1, v.e_done1);
        chk($sformatf("t%0d overflow", k), int'(overflow), v.e_ovf);
        chk($sformatf("t%0d busy_end", k), int'(busy), 0);
    endtask
    initial begin
        int act;
        tbl[0] = '{27, 0, -1, -1, 5'd16, 16'h0001, 16'h0001, 16'h0000,
                   2, 17, 27, 27, 16, 27, 1, 43, -1, 0};
        tbl[1] = '{27, 0, -1, -1, 5'd14, 16'hFFFF, 16'h0000, 16'h0000,
                   2, MASK ? -1 : 17, 27, MASK ? 0 : 27, MASK ? 14 : 16, 27, 1, 43, -1, 0};
        tbl[2] = '{27, 1, -1, -1, 5'd16, 16'h1000, 16'h0100, 16'h0001,
                   2, 17, 27, 27, 16, 53, 1, 69, -1, 0};
        tbl[3] = '{27, 0, 28, -1, 5'd16, 16'h2000, 16'h0003, 16'h0005,
                   2, 17, 28, 28, 16, 29, 1, 43, -1, 1};
        tbl[4] = '{27, 0, -1, 43, 5'd16, 16'h0F00, 16'h0010, 16'h0002,
                   2, 17, 54, 54, 16, 70, 2, 43, 86, 0};
        tbl[5] = '{27, 0, -1, -1, 5'd1, 16'h00A5, 16'h0011, 16'h0003,
                   2, MASK ? -1 : 17, 27, MASK ? 0 : 27, MASK ? 1 : 16, 27, 1, 43, -1, 0};
        do_reset();
        chk("reset ifm_out_nz", int'(|ifm_out), 0);
        chk("reset lane_valid", int'(lane_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset tile_done", int'(tile_done), 0);
        chk("reset overflow", int'(overflow), 0);
        for (int k = 0; k < 6; k++) begin
            do_reset();
            run_stream(tbl[k]);
            check_run(k, tbl[k]);
        end
        // overflow must survive until reset, then clear; then reset mid-tile at strobe 10
        chk("ovf_sticky_pre", int'(overflow), 0);
        do_reset();
        size = 5'd16;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 10) chk("mid busy_before", int'(busy), 1);
            mem_data = (c >= 1) ? vec_data(tbl[0], c - 1) : {N{16'hDEAD}};
            read_en = c < 10;
            rst = c == 10;
        end
        @(negedge clk);
        chk("mid ifm_out_nz", int'(|ifm_out), 0);
        chk("mid lane_valid", int'(lane_valid), 0);
        chk("mid busy", int'(busy), 0);
        chk("mid tile_done", int'(tile_done), 0);
        chk("mid overflow", int'(overflow), 0);
        rst = 1'b0;
        read_en = 1'b0;
        act = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (|lane_valid || tile_done || busy) act++;
        end
        chk("mid no_activity", act, 0);
        run_stream(tbl[0]);
        check_run(6, tbl[0]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
